// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC capture/average stage.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SETTLE  = 2'd2,
    CAPTURE = 2'd3
  } tdc_state_e;

  localparam int TDC_SETTLE_DEF  = 2;
  localparam int TDC_TIMEOUT_DEF = 1024;

  // Width needed to hold a tap count of 0..N inclusive.
  function automatic int tdc_sw(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tdc_capture_avg_if.sv
// Pin/result bundle between the tap line, the capture stage and the output mux.
// Carries bubble_err_o only when TDC_BUBBLE_CHECK_EN is defined.
interface tdc_capture_avg_if #(
  parameter int N_DELAY = 32,
  parameter int SW      = 6
);
  logic               start_i;
  logic               stop_i;
  logic [N_DELAY-1:0] tap_i;
  logic [SW-1:0]      sample_o;
  logic               sample_valid_o;
  logic               ovf_o;
  logic [SW-1:0]      avg_o;
  logic               avg_valid_o;
  logic               busy_o;
`ifdef TDC_BUBBLE_CHECK_EN
  logic               bubble_err_o;
`endif

  modport master (
    output start_i, stop_i, tap_i,
    input  sample_o, sample_valid_o, ovf_o, avg_o, avg_valid_o, busy_o
`ifdef TDC_BUBBLE_CHECK_EN
    , input bubble_err_o
`endif
  );

  modport slave (
    input  start_i, stop_i, tap_i,
    output sample_o, sample_valid_o, ovf_o, avg_o, avg_valid_o, busy_o
`ifdef TDC_BUBBLE_CHECK_EN
    , output bubble_err_o
`endif
  );
endinterface

// File: rtl/tdc_therm_encoder.sv
// Thermometer tap vector to binary count; popcount keeps bubbles from corrupting it.
// Optional clean-code check under TDC_BUBBLE_CHECK_EN.
module tdc_therm_encoder #(
  parameter int N  = 32,
  parameter int SW = 6
) (
  input  logic [N-1:0]  tap,
  output logic [SW-1:0] count
`ifdef TDC_BUBBLE_CHECK_EN
  , output logic        bubble
`endif
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + SW'(tap[i]);
  end

`ifdef TDC_BUBBLE_CHECK_EN
  // A set tap above a clear tap breaks the thermometer shape.
  assign bubble = |(tap[N-1:1] & ~tap[N-2:0]);
`endif

endmodule

// File: rtl/tdc_capture_avg.sv
// Start/stop synchronised TDC capture with settle window, popcount encode and
// power-of-two averaging. Optional bubble check via TDC_BUBBLE_CHECK_EN.
module tdc_capture_avg
  import tdc_pkg::*;
#(
  parameter int N_DELAY        = 32,
  parameter int AVG_LOG2       = 3,
  parameter int SETTLE_CYCLES  = TDC_SETTLE_DEF,
  parameter int TIMEOUT_CYCLES = TDC_TIMEOUT_DEF
) (
  input logic              clk,
  input logic              rst_n,
  tdc_capture_avg_if.slave bus
);

  localparam int SW  = tdc_sw(N_DELAY);
  localparam int AW  = SW + AVG_LOG2;
  localparam int CW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int STW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  // [0],[1] synchroniser, [2] history
  logic [2:0] start_sync, stop_sync;
  logic       start_edge, stop_edge;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      start_sync <= '0;
      stop_sync  <= '0;
    end else begin
      start_sync <= {start_sync[1:0], bus.start_i};
      stop_sync  <= {stop_sync[1:0],  bus.stop_i};
    end
  end

  assign start_edge = start_sync[1] & ~start_sync[2];
  assign stop_edge  = stop_sync[1]  & ~stop_sync[2];

  logic [SW-1:0] enc_count;
  logic          enc_bubble;

  tdc_therm_encoder #(.N(N_DELAY), .SW(SW)) u_enc (
    .tap   (bus.tap_i),
    .count (enc_count)
`ifdef TDC_BUBBLE_CHECK_EN
    , .bubble(enc_bubble)
`endif
  );

`ifndef TDC_BUBBLE_CHECK_EN
  assign enc_bubble = 1'b0;
`endif

  tdc_state_e     state;
  logic [TW-1:0]  tcnt;
  logic [STW-1:0] scnt;
  logic           force_ovf;
  logic [SW-1:0]  sample_q;
  logic           sample_vld, ovf_q, busy_q, bubble_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state      <= IDLE;
      tcnt       <= '0;
      scnt       <= '0;
      force_ovf  <= 1'b0;
      sample_q   <= '0;
      sample_vld <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      bubble_q   <= 1'b0;
    end else begin
      sample_vld <= 1'b0;
      case (state)
        IDLE: if (start_edge) begin
          state     <= RUN;
          tcnt      <= '0;
          force_ovf <= 1'b0;
          busy_q    <= 1'b1;
        end
        RUN: begin
          if (stop_edge) begin
            state <= SETTLE;
            scnt  <= STW'(SETTLE_CYCLES - 1);
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= CAPTURE;
            force_ovf <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        SETTLE: begin
          if (scnt == '0) state <= CAPTURE;
          else            scnt  <= scnt - STW'(1);
        end
        CAPTURE: begin
          state      <= IDLE;
          busy_q     <= 1'b0;
          sample_vld <= 1'b1;
          if (force_ovf) begin
            sample_q <= SW'(N_DELAY);
            ovf_q    <= 1'b1;
            bubble_q <= 1'b0;
          end else begin
            sample_q <= enc_count;
            ovf_q    <= (enc_count == SW'(N_DELAY));
            bubble_q <= enc_bubble;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [AW-1:0] acc, sum, mean;
  logic [CW-1:0] cnt;
  logic [SW-1:0] avg_q;
  logic          avg_vld;

  assign sum  = acc + AW'(sample_q);
  assign mean = sum >> AVG_LOG2;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      avg_q   <= '0;
      avg_vld <= 1'b0;
    end else begin
      avg_vld <= 1'b0;
      if (sample_vld) begin
        if (cnt == CNT_LAST) begin
          avg_q   <= mean[SW-1:0];
          avg_vld <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.sample_o       = sample_q;
  assign bus.sample_valid_o = sample_vld;
  assign bus.ovf_o          = ovf_q;
  assign bus.avg_o          = avg_q;
  assign bus.avg_valid_o    = avg_vld;
  assign bus.busy_o         = busy_q;
`ifdef TDC_BUBBLE_CHECK_EN
  assign bus.bubble_err_o   = bubble_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble_q ^ enc_bubble;
`endif

endmodule

// File: tb/tb_tdc_capture_avg.sv
// Directed bench for tdc_capture_avg (N_DELAY=32, AVG_LOG2=3, SETTLE=2, TIMEOUT=16).
module tb_tdc_capture_avg;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  tdc_capture_avg_if #(.N_DELAY(32), .SW(6)) bus ();

  tdc_capture_avg #(
    .N_DELAY(32), .AVG_LOG2(3), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] therm(input int n);
    logic [63:0] t;
    t = (64'd1 << n) - 64'd1;
    return t[31:0];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick(); tick();
    rst_n = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start_i = 1'b1;
    tick(); tick();
    bus.start_i = 1'b0;
  endtask

  // Raise stop, then watch a fixed window; latencies are counted from the stop rise.
  task automatic stop_collect(output int nv, output logic [5:0] smp, output logic ov,
                              output logic bub, output int lat, output int na,
                              output logic [5:0] av, output int alat);
    nv = 0; na = 0; lat = -1; alat = -1; smp = '0; ov = 1'b0; bub = 1'b0; av = '0;
    bus.stop_i = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 2) bus.stop_i = 1'b0;
      if (bus.sample_valid_o) begin
        nv++;
        if (lat < 0) lat = c;
        smp = bus.sample_o;
        ov  = bus.ovf_o;
`ifdef TDC_BUBBLE_CHECK_EN
        bub = bus.bubble_err_o;
`endif
      end
      if (bus.avg_valid_o) begin
        na++;
        if (alat < 0) alat = c;
        av = bus.avg_o;
      end
    end
  endtask

  task automatic run_meas(input logic [31:0] tap, input int gap, output int nv,
                          output logic [5:0] smp, output logic ov, output logic bub,
                          output int lat, output int na, output logic [5:0] av,
                          output int alat);
    bus.tap_i = tap;
    pulse_start();
    repeat (gap) tick();
    stop_collect(nv, smp, ov, bub, lat, na, av, alat);
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks += 6;
    if (bus.sample_o !== 6'd0)     begin errors++; $display("FAIL reset_sample got %0d exp 0", bus.sample_o); end
    if (bus.sample_valid_o !== 0)  begin errors++; $display("FAIL reset_svalid got %b exp 0", bus.sample_valid_o); end
    if (bus.ovf_o !== 0)           begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.ovf_o); end
    if (bus.avg_o !== 6'd0)        begin errors++; $display("FAIL reset_avg got %0d exp 0", bus.avg_o); end
    if (bus.avg_valid_o !== 0)     begin errors++; $display("FAIL reset_avalid got %b exp 0", bus.avg_valid_o); end
    if (bus.busy_o !== 0)          begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy_o); end
  endtask

  task automatic test_basic();
    int nv, lat, na, alat; logic [5:0] smp, av; logic ov, bub;
    run_meas(32'h0000_00FF, 8, nv, smp, ov, bub, lat, na, av, alat);
    checks += 5;
    if (nv !== 1)      begin errors++; $display("FAIL basic_pulses got %0d exp 1", nv); end
    if (smp !== 6'd8)  begin errors++; $display("FAIL basic_sample got %0d exp 8", smp); end
    if (ov !== 1'b0)   begin errors++; $display("FAIL basic_ovf got %b exp 0", ov); end
    if (lat !== 6)     begin errors++; $display("FAIL basic_latency got %0d exp 6", lat); end
    if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", bus.busy_o); end
  endtask

  task automatic test_boundary();
    int nv, lat, na, alat; logic [5:0] smp, av; logic ov, bub;
    run_meas(32'hFFFF_FFFF, 4, nv, smp, ov, bub, lat, na, av, alat);
    checks += 2;
    if (smp !== 6'd32) begin errors++; $display("FAIL full_sample got %0d exp 32", smp); end
    if (ov !== 1'b1)   begin errors++; $display("FAIL full_ovf got %b exp 1", ov); end
    run_meas(32'h0000_0000, 4, nv, smp, ov, bub, lat, na, av, alat);
    checks += 2;
    if (smp !== 6'd0)  begin errors++; $display("FAIL empty_sample got %0d exp 0", smp); end
    if (ov !== 1'b0)   begin errors++; $display("FAIL empty_ovf got %b exp 0", ov); end
  endtask

  task automatic test_timeout();
    int nv, lat, na, alat, cyc, busy_cnt; logic [5:0] smp, av; logic ov, bub, seen;
    bus.tap_i = 32'h0000_0003;
    bus.start_i = 1'b1;
    cyc = 0; busy_cnt = 0; seen = 1'b0;
    while (cyc < 40 && !seen) begin
      tick();
      cyc++;
      if (cyc == 2) bus.start_i = 1'b0;
      if (bus.busy_o) busy_cnt++;
      if (bus.sample_valid_o) seen = 1'b1;
    end
    checks += 5;
    if (!seen)                 begin errors++; $display("FAIL timeout_seen got 0 exp 1"); end
    if (cyc !== 20)            begin errors++; $display("FAIL timeout_latency got %0d exp 20", cyc); end
    if (busy_cnt !== 17)       begin errors++; $display("FAIL timeout_busy got %0d exp 17", busy_cnt); end
    if (bus.sample_o !== 6'd32) begin errors++; $display("FAIL timeout_sample got %0d exp 32", bus.sample_o); end
    if (bus.ovf_o !== 1'b1)    begin errors++; $display("FAIL timeout_ovf got %b exp 1", bus.ovf_o); end
    repeat (5) tick();
    run_meas(32'h0000_000F, 4, nv, smp, ov, bub, lat, na, av, alat);
    checks += 2;
    if (smp !== 6'd4)  begin errors++; $display("FAIL after_to_sample got %0d exp 4", smp); end
    if (ov !== 1'b0)   begin errors++; $display("FAIL after_to_ovf got %b exp 0", ov); end
  endtask

  task automatic test_averaging();
    int nv, lat, na, alat; logic [5:0] smp, av; logic ov, bub;
    int counts[8] = '{1, 2, 3, 4, 5, 6, 7, 9};
    do_reset();
    for (int k = 0; k < 8; k++) begin
      run_meas(therm(counts[k]), 4, nv, smp, ov, bub, lat, na, av, alat);
      checks += 2;
      if (smp !== 6'(counts[k])) begin errors++; $display("FAIL avg_sample%0d got %0d exp %0d", k, smp, counts[k]); end
      if (na !== (k == 7 ? 1 : 0)) begin errors++; $display("FAIL avg_pulses%0d got %0d exp %0d", k, na, (k == 7 ? 1 : 0)); end
    end
    checks += 2;
    if (av !== 6'd4)   begin errors++; $display("FAIL avg_value got %0d exp 4", av); end
    if (alat !== 7)    begin errors++; $display("FAIL avg_latency got %0d exp 7", alat); end
    for (int k = 0; k < 8; k++) begin
      run_meas(therm(10), 4, nv, smp, ov, bub, lat, na, av, alat);
      checks++;
      if (na !== (k == 7 ? 1 : 0)) begin errors++; $display("FAIL avg2_pulses%0d got %0d exp %0d", k, na, (k == 7 ? 1 : 0)); end
    end
    checks++;
    if (av !== 6'd10)  begin errors++; $display("FAIL avg2_value got %0d exp 10", av); end
  endtask

  task automatic test_edges();
    int nv, lat, na, alat, early; logic [5:0] smp, av; logic ov, bub;
    do_reset();
    bus.tap_i = 32'h0000_003F;
    bus.start_i = 1'b1; bus.stop_i = 1'b1;
    early = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) begin bus.start_i = 1'b0; bus.stop_i = 1'b0; end
      if (bus.sample_valid_o) early++;
    end
    checks += 2;
    if (early !== 0)         begin errors++; $display("FAIL simul_sample got %0d exp 0", early); end
    if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL simul_busy got %b exp 1", bus.busy_o); end
    pulse_start();
    tick();
    stop_collect(nv, smp, ov, bub, lat, na, av, alat);
    checks += 2;
    if (nv !== 1)      begin errors++; $display("FAIL ignored_start_pulses got %0d exp 1", nv); end
    if (smp !== 6'd6)  begin errors++; $display("FAIL ignored_start_sample got %0d exp 6", smp); end
  endtask

  task automatic test_reset_mid();
    int nv, lat, na, alat, spurious; logic [5:0] smp, av; logic ov, bub;
    do_reset();
    for (int k = 0; k < 5; k++) run_meas(therm(3), 4, nv, smp, ov, bub, lat, na, av, alat);
    bus.tap_i = therm(3);
    pulse_start();
    repeat (4) tick();
    bus.stop_i = 1'b1;
    tick(); tick();
    bus.stop_i = 1'b0;
    tick();
    checks++;
    if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", bus.busy_o); end
    rst_n = 1'b1;
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 1) rst_n = 1'b0;
      if (bus.sample_valid_o || bus.avg_valid_o) spurious++;
    end
    checks += 4;
    if (spurious !== 0)        begin errors++; $display("FAIL mid_spurious got %0d exp 0", spurious); end
    if (bus.sample_o !== 6'd0) begin errors++; $display("FAIL mid_sample got %0d exp 0", bus.sample_o); end
    if (bus.avg_o !== 6'd0)    begin errors++; $display("FAIL mid_avg got %0d exp 0", bus.avg_o); end
    if (bus.busy_o !== 1'b0)   begin errors++; $display("FAIL mid_busy got %b exp 0", bus.busy_o); end
    for (int k = 0; k < 8; k++) begin
      run_meas(therm(16), 4, nv, smp, ov, bub, lat, na, av, alat);
      checks++;
      if (na !== (k == 7 ? 1 : 0)) begin errors++; $display("FAIL mid_avg_pulses%0d got %0d exp %0d", k, na, (k == 7 ? 1 : 0)); end
    end
    checks++;
    if (av !== 6'd16)  begin errors++; $display("FAIL mid_avg_value got %0d exp 16", av); end
  endtask

`ifdef TDC_BUBBLE_CHECK_EN
  task automatic test_bubble();
    int nv, lat, na, alat; logic [5:0] smp, av; logic ov, bub;
    run_meas(32'h0000_00F7, 4, nv, smp, ov, bub, lat, na, av, alat);
    checks += 2;
    if (smp !== 6'd7)  begin errors++; $display("FAIL bubble_sample got %0d exp 7", smp); end
    if (bub !== 1'b1)  begin errors++; $display("FAIL bubble_set got %b exp 1", bub); end
    run_meas(32'h0000_00FF, 4, nv, smp, ov, bub, lat, na, av, alat);
    checks++;
    if (bub !== 1'b0)  begin errors++; $display("FAIL bubble_clear got %b exp 0", bub); end
  endtask
`endif

  initial begin
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    bus.tap_i   = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_timeout();
    test_averaging();
    test_edges();
    test_reset_mid();
`ifdef TDC_BUBBLE_CHECK_EN
    test_bubble();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
